// File: rtl/draw_char_16x16_if.sv
// VGA pixel-stream bundle passed between pipeline stages: position, timing and colour.
// The producer uses the master modport and the consumer uses the slave modport.
interface draw_char_16x16_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_char_16x16.sv
// Text overlay: a 16x16 page of 8x16 glyphs drawn into the VGA stream with a two-cycle pipeline.
// Stage 1 addresses the char map and font ROM; stage 2 meets the returned glyph row.
module draw_char_16x16 #(
   parameter int          X_POS  = 100,
   parameter int          Y_POS  = 50,
   parameter logic [11:0] FG_RGB = 12'hfff
) (
   input  logic                     clk,
   input  logic                     rst,
   draw_char_16x16_if.slave         vga_in,
   draw_char_16x16_if.master        vga_out,
   input  logic [7:0]               char_pixels,
   output logic [7:0]               char_xy,
   output logic [3:0]               char_line
);
   localparam logic [10:0] X_LO = 11'(X_POS);
   localparam logic [10:0] X_HI = 11'(X_POS + 128);
   localparam logic [10:0] Y_LO = 11'(Y_POS);
   localparam logic [10:0] Y_HI = 11'(Y_POS + 256);

   logic [10:0] rel_x, rel_y;
   logic        in_box;

   // rel values wrap below the box origin; in_box masks that case out
   assign rel_x  = vga_in.hcount - X_LO;
   assign rel_y  = vga_in.vcount - Y_LO;
   assign in_box = (vga_in.hcount >= X_LO) && (vga_in.hcount < X_HI) &&
                   (vga_in.vcount >= Y_LO) && (vga_in.vcount < Y_HI) &&
                   !vga_in.hblnk && !vga_in.vblnk;

   logic [10:0] hcount_d1_reg, vcount_d1_reg, hcount_d2_reg, vcount_d2_reg;
   logic        hsync_d1_reg, vsync_d1_reg, hblnk_d1_reg, vblnk_d1_reg;
   logic        hsync_d2_reg, vsync_d2_reg, hblnk_d2_reg, vblnk_d2_reg;
   logic [11:0] rgb_d1_reg, rgb_d2_reg;
   logic [2:0]  bitsel_d1_reg, bitsel_d2_reg;
   logic        in_box_d1_reg, in_box_d2_reg;
   logic [7:0]  char_xy_reg;
   logic [3:0]  char_line_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_d1_reg <= '0;
         vcount_d1_reg <= '0;
         hsync_d1_reg  <= 1'b0;
         vsync_d1_reg  <= 1'b0;
         hblnk_d1_reg  <= 1'b0;
         vblnk_d1_reg  <= 1'b0;
         rgb_d1_reg    <= '0;
         bitsel_d1_reg <= '0;
         in_box_d1_reg <= 1'b0;
         char_xy_reg   <= '0;
         char_line_reg <= '0;
         hcount_d2_reg <= '0;
         vcount_d2_reg <= '0;
         hsync_d2_reg  <= 1'b0;
         vsync_d2_reg  <= 1'b0;
         hblnk_d2_reg  <= 1'b0;
         vblnk_d2_reg  <= 1'b0;
         rgb_d2_reg    <= '0;
         bitsel_d2_reg <= '0;
         in_box_d2_reg <= 1'b0;
      end else begin
         hcount_d1_reg <= vga_in.hcount;
         vcount_d1_reg <= vga_in.vcount;
         hsync_d1_reg  <= vga_in.hsync;
         vsync_d1_reg  <= vga_in.vsync;
         hblnk_d1_reg  <= vga_in.hblnk;
         vblnk_d1_reg  <= vga_in.vblnk;
         rgb_d1_reg    <= vga_in.rgb;
         bitsel_d1_reg <= rel_x[2:0];
         in_box_d1_reg <= in_box;
         char_xy_reg   <= {rel_y[7:4], rel_x[6:3]};
         char_line_reg <= rel_y[3:0];
         hcount_d2_reg <= hcount_d1_reg;
         vcount_d2_reg <= vcount_d1_reg;
         hsync_d2_reg  <= hsync_d1_reg;
         vsync_d2_reg  <= vsync_d1_reg;
         hblnk_d2_reg  <= hblnk_d1_reg;
         vblnk_d2_reg  <= vblnk_d1_reg;
         rgb_d2_reg    <= rgb_d1_reg;
         bitsel_d2_reg <= bitsel_d1_reg;
         in_box_d2_reg <= in_box_d1_reg;
      end
   end

   // char_pixels arrives from the registered font ROM in step with the stage-2 registers
   logic pixel_on;
   assign pixel_on = in_box_d2_reg && char_pixels[3'd7 - bitsel_d2_reg];

   assign char_xy        = char_xy_reg;
   assign char_line      = char_line_reg;
   assign vga_out.hcount = hcount_d2_reg;
   assign vga_out.vcount = vcount_d2_reg;
   assign vga_out.hsync  = hsync_d2_reg;
   assign vga_out.vsync  = vsync_d2_reg;
   assign vga_out.hblnk  = hblnk_d2_reg;
   assign vga_out.vblnk  = vblnk_d2_reg;
   assign vga_out.rgb    = pixel_on ? FG_RGB : rgb_d2_reg;
endmodule

// File: tb/tb_draw_char_16x16.sv
// Bench for draw_char_16x16: directed cell/overlay/boundary vectors, a scoreboarded partial frame
// with a char-map/font-ROM model, and asynchronous reset sequences.
module tb_draw_char_16x16;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  char_pixels;
   logic [7:0]  char_xy;
   logic [3:0]  char_line;
   logic        use_model = 1'b0;
   logic [7:0]  pix_force = 8'h00;
   logic [7:0]  rom_q = 8'h00;

   int n_checks = 0;
   int n_fail   = 0;

   draw_char_16x16_if vin ();
   draw_char_16x16_if vout ();

   draw_char_16x16 dut (
      .clk        (clk),
      .rst        (rst),
      .vga_in     (vin),
      .vga_out    (vout),
      .char_pixels(char_pixels),
      .char_xy    (char_xy),
      .char_line  (char_line)
   );

   always #5 clk = ~clk;

   // bench-side character map and font contents
   function automatic logic [6:0] cmap(input logic [7:0] xy);
      return xy[6:0] ^ {xy[7], 6'h15};
   endfunction

   function automatic logic [7:0] font(input logic [10:0] a);
      return a[7:0] ^ {a[10:4], 1'b1};
   endfunction

   always @(posedge clk) rom_q <= font({cmap(char_xy), char_line});
   assign char_pixels = use_model ? rom_q : pix_force;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 20)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hs, input logic vs,
                        input logic hb, input logic vb, input logic [11:0] rgb);
      vin.hcount = h;
      vin.vcount = v;
      vin.hsync  = hs;
      vin.vsync  = vs;
      vin.hblnk  = hb;
      vin.vblnk  = vb;
      vin.rgb    = rgb;
   endtask

   typedef struct {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
      logic [7:0]  pix;
      logic [7:0]  exp_xy;
      logic [3:0]  exp_line;
      logic [11:0] exp_rgb;
   } vec_t;

   typedef struct {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs, vs, hb, vb;
      logic [11:0] rgb;
      logic [7:0]  xy;
      logic [3:0]  line;
   } exp_t;

   vec_t vecs[13];

   function automatic exp_t model(input logic [10:0] h, input logic [10:0] v, input logic hs,
                                  input logic vs, input logic hb, input logic vb,
                                  input logic [11:0] rgb);
      exp_t e;
      logic [10:0] rx, ry;
      logic [7:0]  row;
      logic        inb;
      rx = h - 11'd100;
      ry = v - 11'd50;
      inb = (h >= 100) && (h < 228) && (v >= 50) && (v < 306) && !hb && !vb;
      e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
      e.xy = {ry[7:4], rx[6:3]};
      e.line = ry[3:0];
      row = font({cmap(e.xy), e.line});
      e.rgb = (inb && row[7 - rx[2:0]]) ? 12'hfff : rgb;
      return e;
   endfunction

   initial begin
      exp_t e1, e2, en;
      int   warm;
      logic hs;

      //            h    v  hs hb vb rgb     pix    xy     line  exp_rgb
      vecs[0]  = '{11'd140, 11'd50,  0, 0, 0, 12'h123, 8'h00, 8'h05, 4'h0, 12'h123};
      vecs[1]  = '{11'd116, 11'd69,  0, 0, 0, 12'h456, 8'h00, 8'h12, 4'h3, 12'h456};
      vecs[2]  = '{11'd227, 11'd305, 0, 0, 0, 12'h0ab, 8'hff, 8'hff, 4'hf, 12'hfff};
      vecs[3]  = '{11'd100, 11'd50,  0, 0, 0, 12'h123, 8'h80, 8'h00, 4'h0, 12'hfff};
      vecs[4]  = '{11'd101, 11'd50,  0, 0, 0, 12'h123, 8'h80, 8'h00, 4'h0, 12'h123};
      vecs[5]  = '{11'd99,  11'd60,  0, 0, 0, 12'h321, 8'hff, 8'h0f, 4'ha, 12'h321};
      vecs[6]  = '{11'd228, 11'd60,  0, 0, 0, 12'h321, 8'hff, 8'h00, 4'ha, 12'h321};
      vecs[7]  = '{11'd150, 11'd49,  0, 0, 0, 12'h222, 8'hff, 8'hf6, 4'hf, 12'h222};
      vecs[8]  = '{11'd150, 11'd306, 0, 0, 0, 12'h333, 8'hff, 8'h06, 4'h0, 12'h333};
      vecs[9]  = '{11'd150, 11'd60,  1, 1, 0, 12'h444, 8'hff, 8'h06, 4'ha, 12'h444};
      vecs[10] = '{11'd150, 11'd60,  0, 0, 1, 12'h555, 8'hff, 8'h06, 4'ha, 12'h555};
      vecs[11] = '{11'd107, 11'd50,  0, 0, 0, 12'h666, 8'h01, 8'h00, 4'h0, 12'hfff};
      vecs[12] = '{11'd106, 11'd50,  0, 0, 0, 12'h666, 8'h01, 8'h00, 4'h0, 12'h666};

      // power-on reset: everything zero
      drive(11'd140, 11'd60, 1'b1, 1'b1, 1'b0, 1'b0, 12'habc);
      pix_force = 8'hff;
      repeat (2) @(negedge clk);
      chk("reset_rgb_out", 32'(vout.rgb), 32'h0);
      chk("reset_hcount_out", 32'(vout.hcount), 32'h0);
      chk("reset_char_xy", 32'(char_xy), 32'h0);
      chk("reset_hsync_out", 32'(vout.hsync), 32'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].h, vecs[i].v, vecs[i].hs, 1'b0, vecs[i].hb, vecs[i].vb, vecs[i].rgb);
         pix_force = vecs[i].pix;
         @(negedge clk);
         chk($sformatf("v%0d_char_xy", i), 32'(char_xy), 32'(vecs[i].exp_xy));
         chk($sformatf("v%0d_char_line", i), 32'(char_line), 32'(vecs[i].exp_line));
         @(negedge clk);
         chk($sformatf("v%0d_rgb_out", i), 32'(vout.rgb), 32'(vecs[i].exp_rgb));
         chk($sformatf("v%0d_pos_out", i), {10'd0, vout.vcount, vout.hcount},
             {10'd0, vecs[i].v, vecs[i].h});
         chk($sformatf("v%0d_timing_out", i), {28'd0, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk},
             {28'd0, vecs[i].hs, 1'b0, vecs[i].hb, vecs[i].vb});
         $display("vector %0d h=%0d v=%0d xy=%02h line=%0h rgb_out=%03h", i, vecs[i].h, vecs[i].v,
                  char_xy, char_line, vout.rgb);
      end

      // partial 640x480 frame around the box top, char map + font ROM modelled by the bench
      use_model = 1'b1;
      warm = 0;
      e1 = '{default: '0};
      e2 = '{default: '0};
      for (int v = 44; v < 72; v++) begin
         for (int h = 0; h < 800; h++) begin
            @(negedge clk);
            if (warm >= 2) begin
               chk("frame_rgb_out", 32'(vout.rgb), 32'(e2.rgb));
               chk("frame_pos_out", {10'd0, vout.vcount, vout.hcount}, {10'd0, e2.v, e2.h});
               chk("frame_timing_out", {28'd0, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk},
                   {28'd0, e2.hs, e2.vs, e2.hb, e2.vb});
            end
            if (warm >= 1) begin
               chk("frame_char_xy", 32'(char_xy), 32'(e1.xy));
               chk("frame_char_line", 32'(char_line), 32'(e1.line));
            end
            hs = (h >= 656) && (h < 752);
            drive(11'(h), 11'(v), hs, 1'b0, (h >= 640), 1'b0, {4'(h), 4'(v), 4'(h >> 4)});
            en = model(11'(h), 11'(v), hs, 1'b0, (h >= 640), 1'b0, {4'(h), 4'(v), 4'(h >> 4)});
            e2 = e1;
            e1 = en;
            if (warm < 2) warm++;
         end
         $display("frame line v=%0d done, failures so far %0d", v, n_fail);
      end

      // asynchronous reset mid-line with active in-box inputs
      use_model = 1'b0;
      pix_force = 8'hff;
      @(negedge clk);
      drive(11'd100, 11'd50, 1'b1, 1'b1, 1'b0, 1'b0, 12'h5a5);
      repeat (3) @(negedge clk);
      chk("pre_reset_rgb_out", 32'(vout.rgb), 32'hfff);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_rgb_out", 32'(vout.rgb), 32'h0);
      chk("async_rst_pos_out", {10'd0, vout.vcount, vout.hcount}, 32'h0);
      chk("async_rst_timing_out", {28'd0, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, 32'h0);
      chk("async_rst_char", {20'd0, char_xy, char_line}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_edge1_hcount", 32'(vout.hcount), 32'h0);
      chk("post_rst_edge1_rgb", 32'(vout.rgb), 32'h0);
      @(negedge clk);
      chk("post_rst_edge2_hcount", 32'(vout.hcount), 32'd100);
      chk("post_rst_edge2_rgb", 32'(vout.rgb), 32'hfff);
      chk("post_rst_edge2_hsync", 32'(vout.hsync), 32'h1);
      $display("reset sequence done rgb_out=%03h hcount_out=%0d", vout.rgb, vout.hcount);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
